// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer.
package store_write_buffer_pkg;

  // Store size encodings on st_mask.
  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  // Reserved unsigned-byte encoding; not a legal store size.
  localparam logic [2:0] MASK_BU = 3'b100;

  // Entry addresses are held at this width, zero-extended from the
  // instance address width, so the entry type does not depend on ADDR_W.
  localparam int unsigned WBUF_ADDR_MAX_W = 64;
  localparam int unsigned WBUF_DATA_W     = 32;

  typedef struct packed {
    logic [WBUF_ADDR_MAX_W-1:0] addr;
    logic [WBUF_DATA_W-1:0]     data;
    logic [3:0]                 strb;
  } wbuf_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/wbuf_store_align.sv
// Places LSB-justified store data on its byte lanes and builds the strobe;
// flags illegal size encodings and misaligned halfword/word stores.
module wbuf_store_align
  import store_write_buffer_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic [3:0]  strb,
  output logic        illegal
);

  // Lane placement and legality per store size.
  always_comb begin
    data    = '0;
    strb    = '0;
    illegal = 1'b0;
    case (mask)
      MASK_B: begin
        strb = 4'b0001 << lane;
        data = 32'(wdata[7:0]) << {lane, 3'b000};
      end
      MASK_H: begin
        if (lane[0]) begin
          illegal = 1'b1;
        end else if (lane[1]) begin
          strb = 4'b1100;
          data = {wdata[15:0], 16'h0000};
        end else begin
          strb = 4'b0011;
          data = {16'h0000, wdata[15:0]};
        end
      end
      MASK_W: begin
        if (lane != 2'b00) begin
          illegal = 1'b1;
        end else begin
          strb = 4'b1111;
          data = wdata;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the write-through cache path and main memory.
// Drains one entry per cycle with a req/ack handshake and forwards
// buffered full-word stores to loads.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [2:0]        st_mask,
  output logic              st_ready,
  output logic              st_err,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              ld_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  output logic              empty
);

  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  wbuf_entry_t              entries [DEPTH];
  logic [DEPTH-1:0]         valid;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W:0]           count;
  logic [PTR_W:0]           count_nxt;
  drain_state_t             state;
  drain_state_t             state_nxt;

  logic [31:0]              al_data;
  logic [3:0]               al_strb;
  logic                     al_illegal;
  logic                     push;
  logic                     pop;
  wbuf_entry_t              new_entry;

  logic [WBUF_ADDR_MAX_W-1:0] ld_word;
  logic [PTR_W-1:0]         fwd_idx;
  logic                     match;
  logic [31:0]              match_data;
  logic [3:0]               match_strb;
  logic                     unused_ld_lanes;

  wbuf_store_align u_align (
    .mask    (st_mask),
    .lane    (st_addr[1:0]),
    .wdata   (st_wdata),
    .data    (al_data),
    .strb    (al_strb),
    .illegal (al_illegal)
  );

  assign st_ready = (count < DEPTH_CNT);
  assign empty    = (count == '0);
  assign push     = st_valid & st_ready & ~al_illegal;
  assign pop      = (state == ISSUE) & mem_ack;

  assign new_entry.addr = WBUF_ADDR_MAX_W'({st_addr[ADDR_W-1:2], 2'b00});
  assign new_entry.data = al_data;
  assign new_entry.strb = al_strb;

  assign mem_req   = (state == ISSUE);
  assign mem_addr  = entries[head].addr[ADDR_W-1:0];
  assign mem_wdata = entries[head].data;
  assign mem_wstrb = entries[head].strb;

  // Occupancy after this cycle's enqueue/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (PTR_W+1)'(1);
    end else if (!push && pop) begin
      count_nxt = count - (PTR_W+1)'(1);
    end
  end

  // FIFO storage, pointers, occupancy and registered store error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      valid  <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      if (push) begin
        entries[tail] <= new_entry;
        valid[tail]   <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count  <= count_nxt;
      st_err <= st_valid & al_illegal;
    end
  end

  // Drain state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain next-state: issue while entries remain, idle once the last one pops.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      ISSUE:   if (pop && (count_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_word         = WBUF_ADDR_MAX_W'(ld_addr);
  assign unused_ld_lanes = ^ld_word[1:0];

  // Walk entries oldest to youngest so the youngest word match is kept.
  always_comb begin
    fwd_idx    = head;
    match      = 1'b0;
    match_data = '0;
    match_strb = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if (valid[fwd_idx] &&
          (entries[fwd_idx].addr[WBUF_ADDR_MAX_W-1:2] == ld_word[WBUF_ADDR_MAX_W-1:2])) begin
        match      = 1'b1;
        match_data = entries[fwd_idx].data;
        match_strb = entries[fwd_idx].strb;
      end
    end
  end

  assign fwd_hit  = ld_valid & match & (match_strb == 4'b1111);
  assign ld_stall = ld_valid & match & (match_strb != 4'b1111);
  assign fwd_data = fwd_hit ? match_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: expected memory writes are
// queued as stores are accepted and matched against each mem handshake.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [2:0]  st_mask;
  logic        st_ready;
  logic        st_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        ld_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        empty;

  logic        ack_mode = 1'b0;
  logic        ack_man  = 1'b0;
  logic        ack_rand = 1'b0;
  int          ack_wait = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_w;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr  = 0;
  logic pend_err = 1'b0;

  always #5 clk = ~clk;

  assign mem_ack = ack_mode ? ack_rand : ack_man;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_mask(st_mask),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .empty(empty)
  );

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference store model: legality, lane placement and strobe.
  function automatic void model(input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] d, output logic legal, output wr_t w);
    int lo;
    legal  = 1'b0;
    w      = '0;
    w.addr = {a[31:2], 2'b00};
    case (m)
      3'b000: begin
        legal = 1'b1;
        lo = int'(a[1:0]);
        w.strb[lo] = 1'b1;
        w.data[8*lo +: 8] = d[7:0];
      end
      3'b001: if (!a[0]) begin
        legal = 1'b1;
        lo = a[1] ? 2 : 0;
        w.strb[lo] = 1'b1;
        w.strb[lo+1] = 1'b1;
        w.data[8*lo +: 16] = d[15:0];
      end
      3'b010: if (a[1:0] == 2'b00) begin
        legal = 1'b1;
        w.strb = 4'hF;
        w.data = d;
      end
      default: ;
    endcase
  endfunction

  // Randomly delayed ack, 0-3 cycles between accepted writes.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (ack_wait == 0) begin
        ack_rand = 1'b1;
        ack_wait = $urandom_range(0, 3);
      end else begin
        ack_rand = 1'b0;
        ack_wait--;
      end
    end else begin
      ack_rand = 1'b0;
    end
  end

  // Memory-side monitor: every accepted write must be the next expected one.
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {mem_addr, mem_wdata, mem_wstrb}, '0);
      end else begin
        mon_w = exp_q.pop_front();
        check("mem_wr", {mem_addr, mem_wdata, mem_wstrb}, mon_w);
        n_wr++;
      end
    end
  end

  task automatic store_drive(input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d, output bit acc);
    wr_t  w;
    logic legal;
    model(m, a, d, legal, w);
    st_valid = 1'b1;
    st_mask  = m;
    st_addr  = a;
    st_wdata = d;
    acc      = legal && st_ready;
    pend_err = !legal;
    if (acc) exp_q.push_back(w);
  endtask

  task automatic store_finish();
    @(posedge clk); #1;
    st_valid = 1'b0;
    check("st_err", st_err, pend_err);
  endtask

  task automatic do_store(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    store_drive(m, a, d, acc);
    store_finish();
  endtask

  task automatic ack_once();
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
  endtask

  task automatic wait_req(input int maxc);
    for (int i = 0; i < maxc && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    check("mem_req_up", mem_req, 1'b1);
  endtask

  task automatic wait_drained(input int maxc);
    for (int i = 0; i < maxc && !(empty && exp_q.size() == 0); i++) begin
      @(posedge clk); #1;
    end
    check("drained_empty", empty, 1'b1);
    check("drained_sb", exp_q.size(), 0);
  endtask

  initial begin
    logic [2:0]  bad_m [4];
    logic [31:0] bad_a [4];
    int          base;
    bit          acc;

    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_mask = '0;
    ld_valid = 1'b0; ld_addr = '0;

    // Reset state.
    #12;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_st_err", st_err, 1'b0);
    check("rst_fwd", {fwd_hit, ld_stall}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Byte and halfword lane placement.
    do_store(3'b000, 32'h103, 32'hAB);
    do_store(3'b001, 32'h102, 32'h1234);
    wait_req(5);
    check("sb_head", {mem_addr, mem_wdata, mem_wstrb}, {32'h100, 32'hAB000000, 4'b1000});
    ack_once();
    check("sh_head", {mem_addr, mem_wdata, mem_wstrb}, {32'h100, 32'h12340000, 4'b1100});
    ack_once();
    check("drain_empty", empty, 1'b1);
    check("drain_idle", mem_req, 1'b0);

    // Fill, hold when full, pop/push interaction.
    for (int i = 0; i < 4; i++) do_store(3'b010, 32'h300 + 32'(4*i), 32'hC0DE0000 + 32'(i));
    check("full_ready", st_ready, 1'b0);
    store_drive(3'b010, 32'h310, 32'hC0DE0004, acc);
    store_finish();
    check("full_hold", st_ready, 1'b0);
    wait_req(5);
    ack_man = 1'b1;
    store_drive(3'b010, 32'h310, 32'hC0DE0004, acc);
    store_finish();
    ack_man = 1'b0;
    check("ack_full_ready", st_ready, 1'b1);
    do_store(3'b010, 32'h310, 32'hC0DE0004);
    check("refull_ready", st_ready, 1'b0);
    ack_once();
    ack_man = 1'b1;
    do_store(3'b000, 32'h314, 32'h5A);
    ack_man = 1'b0;
    check("pushpop_ready", st_ready, 1'b1);
    do_store(3'b001, 32'h318, 32'h6B6B);
    check("pushpop_full", st_ready, 1'b0);
    ack_mode = 1'b1;
    wait_drained(100);
    ack_mode = 1'b0;

    // Forwarding: youngest wins, partial stalls until drained.
    do_store(3'b010, 32'h200, 32'h11111111);
    do_store(3'b010, 32'h200, 32'h22222222);
    ld_valid = 1'b1; ld_addr = 32'h202; #1;
    check("fwd_young", {fwd_hit, ld_stall, fwd_data}, {2'b10, 32'h22222222});
    ld_addr = 32'h300; #1;
    check("fwd_miss", {fwd_hit, ld_stall, fwd_data}, '0);
    ld_valid = 1'b0; ld_addr = 32'h200; #1;
    check("fwd_noload", {fwd_hit, ld_stall, fwd_data}, '0);
    ld_valid = 1'b1;
    store_drive(3'b000, 32'h200, 32'h55, acc);
    #1;
    check("fwd_same_cycle", {fwd_hit, ld_stall, fwd_data}, {2'b10, 32'h22222222});
    store_finish();
    check("stall_partial", {fwd_hit, ld_stall, fwd_data}, {2'b01, 32'h0});
    ack_once();
    check("stall_after1", ld_stall, 1'b1);
    ack_once();
    check("stall_after2", ld_stall, 1'b1);
    ack_man = 1'b1; #1;
    check("stall_popping", ld_stall, 1'b1);
    @(posedge clk); #1;
    ack_man = 1'b0;
    check("stall_cleared", {fwd_hit, ld_stall, empty}, 3'b001);
    ld_valid = 1'b0;

    // Illegal stores: one-cycle error, nothing enqueued.
    bad_m = '{3'b011, 3'b001, 3'b010, 3'b100};
    bad_a = '{32'h100, 32'h101, 32'h202, 32'h100};
    for (int i = 0; i < 4; i++) begin
      do_store(bad_m[i], bad_a[i], 32'hDEADBEEF);
      @(posedge clk); #1;
      check("err_pulse_end", st_err, 1'b0);
      check("err_no_entry", {empty, mem_req}, 2'b10);
    end

    // Eight random stores with wrap-around and random ack delays.
    ack_mode = 1'b1;
    base = n_wr;
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  m;
      logic [31:0] a;
      int          tries;
      m = 3'($urandom_range(0, 2));
      a = 32'h1000 + 32'(16 * i) + ((m == 3'b000) ? 32'($urandom_range(0, 3)) :
                                    (m == 3'b001) ? 32'(2 * $urandom_range(0, 1)) : 32'h0);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        store_drive(m, a, $urandom, acc);
        store_finish();
        tries++;
      end
      check("rand_accept", acc, 1'b1);
    end
    wait_drained(200);
    check("rand_wr_count", n_wr - base, 8);
    ack_mode = 1'b0;

    // Reset asserted mid-handshake.
    do_store(3'b010, 32'h500, 32'h0BADF00D);
    wait_req(5);
    reset = 1'b0; #1;
    check("rst_mid_req", mem_req, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_mid_state", {empty, st_ready, mem_req}, 3'b110);
    repeat (3) @(posedge clk);
    #1;
    check("rst_lost", {empty, mem_req}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
